wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order write-back stage and the long-latency unit (LLU: mul/div).
//  The write-back stage has priority. LLU results wait in a 2-entry FIFO and drain into idle write-port cycles.
//  A starvation counter forces a pipeline stall once the FIFO head has waited too long.

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline (master) and the register-file write-port arbiter (slave).
// Signal names keep the arbiter's point of view for direction suffixes.
interface wb_port_arbiter_if #(
  parameter int unsigned XLEN = 64
);
  logic            wb_wen_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            stall_o;
  logic            issue_i;
  logic [4:0]      issue_rd_i;
  logic            issue_ready_o;
  logic [31:0]     busy_o;
  logic            llu_valid_i;
  logic            llu_ready_o;
  logic [4:0]      llu_rd_i;
  logic [XLEN-1:0] llu_data_i;
  logic            rf_wen_o;
  logic [4:0]      rf_addr_o;
  logic [XLEN-1:0] rf_data_o;

  modport slave (
    input  wb_wen_i, wb_rd_i, wb_data_i, issue_i, issue_rd_i, llu_valid_i, llu_rd_i, llu_data_i,
    output stall_o, issue_ready_o, busy_o, llu_ready_o, rf_wen_o, rf_addr_o, rf_data_o
  );

  modport master (
    output wb_wen_i, wb_rd_i, wb_data_i, issue_i, issue_rd_i, llu_valid_i, llu_rd_i, llu_data_i,
    input  stall_o, issue_ready_o, busy_o, llu_ready_o, rf_wen_o, rf_addr_o, rf_data_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between write-back (priority) and queued LLU results,
// with a starvation-forced stall slot and an LLU busy scoreboard.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic               clk_sys_i,
  input logic               rst_sys_i,
  wb_port_arbiter_if.slave  bus
);
  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic [4:0]      fifo_rd_q   [2];
  logic [XLEN-1:0] fifo_data_q [2];
  logic [31:0]     busy_q, busy_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;

  logic            stall, push, pop, wb_grant;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign stall     = (state_q == StForce);
  assign push      = bus.llu_valid_i && (count_q != 2'd2);
  assign wb_grant  = !stall && bus.wb_wen_i && (bus.wb_rd_i != 5'd0);
  // Forced slot falls out naturally: stall suppresses wb_grant, so the head pops.
  assign pop       = (count_q != 2'd0) && !wb_grant;
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_grant) begin
      rf_wen_d  = 1'b1;
      rf_addr_d = bus.wb_rd_i;
      rf_data_d = bus.wb_data_i;
    end else if (pop && (head_rd != 5'd0)) begin
      rf_wen_d  = 1'b1;
      rf_addr_d = head_rd;
      rf_data_d = head_data;
    end
  end

  // Set after clear so a same-cycle issue wins; re-issuing a busy rd leaves it set.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (bus.issue_i) busy_d[bus.issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (push) state_d = StWait;
      end
      StWait: begin
        if (pop) begin
          cnt_d   = 8'd0;
          state_d = (count_d == 2'd0) ? StIdle : StWait;
        end else begin
          if (cnt_q < Limit) cnt_d = cnt_q + 8'd1;
          if (cnt_d == Limit) state_d = StForce;
        end
      end
      StForce: begin
        cnt_d   = 8'd0;
        state_d = (count_d == 2'd0) ? StIdle : StWait;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      busy_q    <= 32'd0;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_sys_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.llu_rd_i;
      fifo_data_q[wr_ptr_q] <= bus.llu_data_i;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.issue_ready_o = !busy_q[bus.issue_rd_i];
  assign bus.busy_o        = busy_q;
  assign bus.llu_ready_o   = (count_q != 2'd2);
  assign bus.rf_wen_o      = rf_wen_q;
  assign bus.rf_addr_o     = rf_addr_q;
  assign bus.rf_data_o     = rf_data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, priority, starvation, FIFO full, x0 and scoreboard.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(64)) bus ();

  wb_port_arbiter #(
    .XLEN         (64),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic wen, input logic [4:0] addr,
                        input logic [63:0] data);
    chk({tag, ".wen"},  64'(bus.rf_wen_o),  64'(wen));
    chk({tag, ".addr"}, 64'(bus.rf_addr_o), 64'(addr));
    chk({tag, ".data"}, bus.rf_data_o,      data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wb_wen_i    = 1'b0;
    bus.wb_rd_i     = 5'd0;
    bus.wb_data_i   = 64'd0;
    bus.issue_i     = 1'b0;
    bus.issue_rd_i  = 5'd0;
    bus.llu_valid_i = 1'b0;
    bus.llu_rd_i    = 5'd0;
    bus.llu_data_i  = 64'd0;
  endtask

  task automatic llu_push(input logic [4:0] rd, input logic [63:0] data);
    bus.llu_valid_i = 1'b1;
    bus.llu_rd_i    = rd;
    bus.llu_data_i  = data;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [63:0] data);
    bus.wb_wen_i  = 1'b1;
    bus.wb_rd_i   = rd;
    bus.wb_data_i = data;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // T1: reset while traffic is active
    wb_write(5'd1, 64'h11);
    llu_push(5'd4, 64'h44);
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd3;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk_rf("t1_rst", 1'b0, 5'd0, 64'd0);
    chk("t1_stall", 64'(bus.stall_o), 64'd0);
    chk("t1_busy", 64'(bus.busy_o), 64'd0);
    chk("t1_ready", 64'(bus.llu_ready_o), 64'd1);
    rst = 1'b0;
    idle_in();
    tick();
    chk("t1_fifo_empty", 64'(bus.rf_wen_o), 64'd0);
    chk("t1_busy_after", 64'(bus.busy_o), 64'd0);

    // T2: write-back priority over a same-cycle LLU push
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd6;
    tick();
    chk("t2_busy_set", 64'(bus.busy_o), 64'h40);
    idle_in();
    wb_write(5'd5, 64'hA);
    llu_push(5'd6, 64'hB);
    tick();
    chk_rf("t2_wb", 1'b1, 5'd5, 64'hA);
    chk("t2_busy_held", 64'(bus.busy_o), 64'h40);
    idle_in();
    tick();
    chk_rf("t2_llu", 1'b1, 5'd6, 64'hB);
    chk("t2_busy_clr", 64'(bus.busy_o), 64'd0);
    tick();
    chk_rf("t2_idle_hold", 1'b0, 5'd6, 64'hB);

    // T3: starvation forces exactly one stall slot after 8 waits
    wb_write(5'd10, 64'h100);
    llu_push(5'd8, 64'hC);
    tick();
    chk_rf("t3_wb0", 1'b1, 5'd10, 64'h100);
    bus.llu_valid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.wb_data_i = 64'h100 + 64'(i);
      tick();
      chk("t3_wb_data", bus.rf_data_o, 64'h100 + 64'(i));
      chk("t3_stall", 64'(bus.stall_o), 64'(i == 8));
    end
    tick();
    chk_rf("t3_forced", 1'b1, 5'd8, 64'hC);
    chk("t3_stall_drop", 64'(bus.stall_o), 64'd0);
    tick();
    chk_rf("t3_held_wb", 1'b1, 5'd10, 64'h108);
    idle_in();
    tick();
    chk("t3_idle", 64'(bus.rf_wen_o), 64'd0);

    // T4: FIFO full under continuous write-back; order preserved
    wb_write(5'd11, 64'h200);
    llu_push(5'd12, 64'h21);
    tick();
    bus.wb_data_i = 64'h201;
    llu_push(5'd13, 64'h22);
    #1;
    chk("t4_ready_1", 64'(bus.llu_ready_o), 64'd1);
    tick();
    chk("t4_wb1", bus.rf_data_o, 64'h201);
    llu_push(5'd14, 64'h23);
    for (int i = 2; i <= 8; i++) begin
      bus.wb_data_i = 64'h200 + 64'(i);
      #1;
      chk("t4_full", 64'(bus.llu_ready_o), 64'd0);
      tick();
      chk("t4_wb_data", bus.rf_data_o, 64'h200 + 64'(i));
    end
    chk("t4_stall", 64'(bus.stall_o), 64'd1);
    chk("t4_full_force", 64'(bus.llu_ready_o), 64'd0);
    tick();
    chk_rf("t4_pop12", 1'b1, 5'd12, 64'h21);
    chk("t4_ready_after_pop", 64'(bus.llu_ready_o), 64'd1);
    tick();
    chk_rf("t4_held_wb", 1'b1, 5'd11, 64'h208);
    idle_in();
    tick();
    chk_rf("t4_pop13", 1'b1, 5'd13, 64'h22);
    tick();
    chk_rf("t4_pop14", 1'b1, 5'd14, 64'h23);
    tick();
    chk("t4_drained", 64'(bus.rf_wen_o), 64'd0);

    // T5: x0 write-back leaves the port free; rd=0 LLU result pops silently
    llu_push(5'd7, 64'h1);
    tick();
    idle_in();
    wb_write(5'd0, 64'hDEAD);
    tick();
    chk_rf("t5_x7", 1'b1, 5'd7, 64'h1);
    idle_in();
    llu_push(5'd0, 64'h55);
    tick();
    idle_in();
    tick();
    chk_rf("t5_rd0_pop", 1'b0, 5'd7, 64'h1);
    llu_push(5'd15, 64'h77);
    tick();
    idle_in();
    tick();
    chk_rf("t5_next", 1'b1, 5'd15, 64'h77);

    // T6: scoreboard set/clear and protocol-error re-issue
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd9;
    #1;
    chk("t6_ready_free", 64'(bus.issue_ready_o), 64'd1);
    tick();
    chk("t6_busy_set", 64'(bus.busy_o), 64'h200);
    chk("t6_ready_busy", 64'(bus.issue_ready_o), 64'd0);
    tick();
    chk("t6_busy_reissue", 64'(bus.busy_o), 64'h200);
    idle_in();
    llu_push(5'd9, 64'h99);
    tick();
    idle_in();
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd9;
    tick();
    chk_rf("t6_pop9", 1'b1, 5'd9, 64'h99);
    chk("t6_set_wins", 64'(bus.busy_o), 64'h200);
    idle_in();
    llu_push(5'd9, 64'h9A);
    tick();
    idle_in();
    tick();
    chk_rf("t6_pop9b", 1'b1, 5'd9, 64'h9A);
    chk("t6_busy_clr", 64'(bus.busy_o), 64'd0);
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd0;
    tick();
    chk("t6_x0_never_busy", 64'(bus.busy_o), 64'd0);
    chk("t6_x0_ready", 64'(bus.issue_ready_o), 64'd1);
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
